// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   Decode-to-execute issue stage. Turns opcode/funct3/funct7[5] into a 3-bit
//   ALU operation, picks operand A (rs1 / PC / zero) and operand B
//   (rs2 / immediate), and holds the result in a one-entry ID/EX slot with a
//   valid/ready handshake and flush.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake (decoded fields present)
//   opcode, funct3, funct7b5 instruction decode fields
//   rd1, rd2, imm, pc        operand sources
//   flush                    kill the held and the incoming instruction
//   out_valid / out_ready    downstream handshake towards execute
//   ALUSrcA, ALUSrcB         registered ALU operands
//   ALUControl               registered ALU op (ADD SUB AND OR SLT XOR SLL SRL)
//   is_branch, branch_ne     conditional branch, BNE vs BEQ
//   illegal                  unsupported encoding, travels with out_valid
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic [DATA_WIDTH-1:0] rd1,
    input  logic [DATA_WIDTH-1:0] rd2,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUSrcA,
    output logic [DATA_WIDTH-1:0] ALUSrcB,
    output logic [2:0]            ALUControl,
    output logic                  is_branch,
    output logic                  branch_ne,
    output logic                  illegal
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [DATA_WIDTH-1:0] w_opa;
    logic [DATA_WIDTH-1:0] w_opb;
    logic [DATA_WIDTH-1:0] w_opb_raw;
    logic [2:0]            w_ctl;
    logic [2:0]            w_ctl_raw;
    logic                  w_ill;
    logic                  w_br;
    logic                  w_bne;
    logic                  w_load;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [2:0]            r_ctl;
    logic                  r_br;
    logic                  r_bne;
    logic                  r_ill;

    // funct3 -> ALU op shared by R-type and I-ALU; 011 (SLTU) is unsupported.
    function automatic logic [3:0] f3_map(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_map = {1'b0, ALU_ADD};
            3'b111:  f3_map = {1'b0, ALU_AND};
            3'b110:  f3_map = {1'b0, ALU_OR};
            3'b010:  f3_map = {1'b0, ALU_SLT};
            3'b100:  f3_map = {1'b0, ALU_XOR};
            3'b001:  f3_map = {1'b0, ALU_SLL};
            3'b101:  f3_map = {1'b0, ALU_SRL};
            default: f3_map = {1'b1, ALU_ADD};
        endcase
    endfunction

    always_comb begin
        w_opa     = '0;
        w_opb_raw = '0;
        w_ctl_raw = ALU_ADD;
        w_ill     = 1'b0;
        w_br      = 1'b0;
        w_bne     = 1'b0;
        case (opcode)
            OP_R: begin
                w_opa     = rd1;
                w_opb_raw = rd2;
                {w_ill, w_ctl_raw} = f3_map(funct3);
                // funct7[5] only legal as the SUB selector
                if (funct3 == 3'b000) begin
                    if (funct7b5) w_ctl_raw = ALU_SUB;
                end else if (funct7b5) begin
                    w_ill = 1'b1;
                end
            end
            OP_I: begin
                w_opa     = rd1;
                w_opb_raw = imm;
                {w_ill, w_ctl_raw} = f3_map(funct3);
                // instr[30] is an immediate bit except for shifts (SRAI is unsupported)
                if ((funct3 == 3'b001 || funct3 == 3'b101) && funct7b5) w_ill = 1'b1;
            end
            OP_LOAD, OP_STORE, OP_JALR: begin
                w_opa     = rd1;
                w_opb_raw = imm;
            end
            OP_LUI: begin
                w_opb_raw = imm;
            end
            OP_AUIPC: begin
                w_opa     = pc;
                w_opb_raw = imm;
            end
            OP_BRANCH: begin
                w_opa     = rd1;
                w_opb_raw = rd2;
                w_ctl_raw = ALU_SUB;
                w_br      = 1'b1;
                w_bne     = funct3[0];
                if (funct3[2:1] != 2'b00) w_ill = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Shifts see only the shift amount; illegal encodings are squashed to a
    // harmless ADD 0+0 so execute never acts on garbage.
    always_comb begin
        w_opb = w_opb_raw;
        if (w_ctl_raw == ALU_SLL || w_ctl_raw == ALU_SRL)
            w_opb = {{(DATA_WIDTH-SHAMT_WIDTH){1'b0}}, w_opb_raw[SHAMT_WIDTH-1:0]};
        w_ctl = w_ctl_raw;
        if (w_ill) begin
            w_ctl = ALU_ADD;
            w_opb = '0;
        end
    end

    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_ctl   <= ALU_ADD;
            r_br    <= 1'b0;
            r_bne   <= 1'b0;
            r_ill   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_a     <= w_ill ? '0 : w_opa;
            r_b     <= w_opb;
            r_ctl   <= w_ctl;
            r_br    <= w_br && !w_ill;
            r_bne   <= w_bne && !w_ill;
            r_ill   <= w_ill;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign ALUSrcA    = r_a;
    assign ALUSrcB    = r_b;
    assign ALUControl = r_ctl;
    // qualified so a drained/flushed slot never advertises a branch or trap
    assign is_branch  = r_valid && r_br;
    assign branch_ne  = r_bne;
    assign illegal    = r_valid && r_ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//   Directed stimulus; each accepted instruction pushes its hand-computed
//   expected outputs onto a queue, and the head is compared every cycle the
//   slot is valid, popped on consume, and discarded on flush/reset.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctl;
        logic        br;
        logic        bne;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] rd1, rd2, imm, pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUSrcA, ALUSrcB;
    logic [2:0]  ALUControl;
    logic        is_branch, branch_ne, illegal;

    exp_t q[$];
    exp_t pend;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rd1(rd1), .rd2(rd2), .imm(imm), .pc(pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .is_branch(is_branch), .branch_ne(branch_ne), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a_rd1, input logic [31:0] a_rd2,
                        input logic [31:0] a_imm, input logic [31:0] a_pc,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] ectl,
                        input logic ebr, input logic ebne, input logic eill);
        in_valid = 1'b1;
        opcode = op; funct3 = f3; funct7b5 = f7;
        rd1 = a_rd1; rd2 = a_rd2; imm = a_imm; pc = a_pc;
        pend.a = ea; pend.b = eb; pend.ctl = ectl;
        pend.br = ebr; pend.bne = ebne; pend.ill = eill;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Mid-cycle check against the model, then advance the model and the clock.
    task automatic cyc(input string tag);
        bit ov;
        @(negedge clk);
        ov = (q.size() != 0);
        chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, ov});
        chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, (!ov || out_ready)});
        if (ov) begin
            chk({tag, ".A"},      ALUSrcA, q[0].a);
            chk({tag, ".B"},      ALUSrcB, q[0].b);
            chk({tag, ".ctl"},    {29'b0, ALUControl}, {29'b0, q[0].ctl});
            chk({tag, ".br"},     {31'b0, is_branch}, {31'b0, q[0].br});
            chk({tag, ".bne"},    {31'b0, branch_ne}, {31'b0, q[0].bne});
            chk({tag, ".ill"},    {31'b0, illegal},   {31'b0, q[0].ill});
        end else begin
            chk({tag, ".ill_idle"}, {31'b0, illegal},   32'd0);
            chk({tag, ".br_idle"},  {31'b0, is_branch}, 32'd0);
        end
        if (rst || flush) begin
            q.delete();
        end else begin
            if (ov && out_ready) void'(q.pop_front());
            if (in_valid && (!ov || out_ready)) q.push_back(pend);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".A"},   ALUSrcA, 32'd0);
        chk({tag, ".B"},   ALUSrcB, 32'd0);
        chk({tag, ".ctl"}, {29'b0, ALUControl}, 32'd0);
        chk({tag, ".br"},  {31'b0, is_branch}, 32'd0);
        chk({tag, ".bne"}, {31'b0, branch_ne}, 32'd0);
        chk({tag, ".ill"}, {31'b0, illegal},   32'd0);
        chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        opcode = '0; funct3 = '0; funct7b5 = 1'b0;
        rd1 = '0; rd2 = '0; imm = '0; pc = '0;
        pend = '{default: '0};
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // ---- decode coverage, consumer always ready ----
        send(7'b0110011, 3'b000, 1'b1, 32'h10, 32'h3, 0, 0,  32'h10, 32'h3, 3'b001, 0, 0, 0); cyc("sub");
        send(7'b0010011, 3'b001, 1'b0, 32'hAB, 0, 32'hFFFFFFE3, 0, 32'hAB, 32'h3, 3'b110, 0, 0, 0); cyc("slli");
        send(7'b0110011, 3'b101, 1'b0, 32'h80000000, 32'h25, 0, 0, 32'h80000000, 32'h5, 3'b111, 0, 0, 0); cyc("srl");
        send(7'b0010111, 3'b000, 1'b0, 32'h99, 0, 32'h5000, 32'h1000, 32'h1000, 32'h5000, 3'b000, 0, 0, 0); cyc("auipc");
        send(7'b0110111, 3'b011, 1'b0, 32'h77, 0, 32'h12345000, 32'h40, 32'h0, 32'h12345000, 3'b000, 0, 0, 0); cyc("lui");
        send(7'b1100011, 3'b001, 1'b0, 32'h5, 32'h7, 32'h10, 0, 32'h5, 32'h7, 3'b001, 1, 1, 0); cyc("bne");
        send(7'b1100011, 3'b000, 1'b0, 32'h9, 32'h9, 32'h10, 0, 32'h9, 32'h9, 3'b001, 1, 0, 0); cyc("beq");
        send(7'b1100011, 3'b100, 1'b0, 32'h5, 32'h7, 32'h10, 0, 32'h0, 32'h0, 3'b000, 0, 0, 1); cyc("blt_ill");
        send(7'b0110011, 3'b101, 1'b1, 32'h8, 32'h1, 0, 0, 32'h0, 32'h0, 3'b000, 0, 0, 1); cyc("sra_ill");
        send(7'b0110011, 3'b011, 1'b0, 32'h8, 32'h1, 0, 0, 32'h0, 32'h0, 3'b000, 0, 0, 1); cyc("sltu_ill");
        send(7'b0110011, 3'b111, 1'b1, 32'h8, 32'h1, 0, 0, 32'h0, 32'h0, 3'b000, 0, 0, 1); cyc("and_f7_ill");
        send(7'b1111111, 3'b000, 1'b0, 32'h8, 32'h1, 32'h2, 0, 32'h0, 32'h0, 3'b000, 0, 0, 1); cyc("op_ill");
        send(7'b0010011, 3'b101, 1'b1, 32'h8, 0, 32'h40000403, 0, 32'h0, 32'h0, 3'b000, 0, 0, 1); cyc("srai_ill");
        send(7'b0110011, 3'b111, 1'b0, 32'hF0F0, 32'hFF00, 0, 0, 32'hF0F0, 32'hFF00, 3'b010, 0, 0, 0); cyc("and");
        send(7'b0010011, 3'b110, 1'b1, 32'h1, 0, 32'hFFFFF800, 0, 32'h1, 32'hFFFFF800, 3'b011, 0, 0, 0); cyc("ori");
        send(7'b0010011, 3'b010, 1'b0, 32'h3, 0, 32'h7, 0, 32'h3, 32'h7, 3'b100, 0, 0, 0); cyc("slti");
        send(7'b0110011, 3'b100, 1'b0, 32'hAA, 32'h55, 0, 0, 32'hAA, 32'h55, 3'b101, 0, 0, 0); cyc("xor");
        send(7'b0010011, 3'b000, 1'b1, 32'h100, 0, 32'hFFFFFC00, 0, 32'h100, 32'hFFFFFC00, 3'b000, 0, 0, 0); cyc("addi_f7");
        send(7'b0000011, 3'b010, 1'b0, 32'h2000, 0, 32'h4, 0, 32'h2000, 32'h4, 3'b000, 0, 0, 0); cyc("load");
        send(7'b0100011, 3'b010, 1'b1, 32'h3000, 32'h5, 32'hFFFFFFFC, 0, 32'h3000, 32'hFFFFFFFC, 3'b000, 0, 0, 0); cyc("store");
        send(7'b1100111, 3'b000, 1'b0, 32'h400, 0, 32'h8, 32'h10, 32'h400, 32'h8, 3'b000, 0, 0, 0); cyc("jalr");
        idle(); cyc("drain");
        cyc("empty");

        // ---- back-pressure ----
        send(7'b0110011, 3'b000, 1'b0, 32'h11, 32'h22, 0, 0, 32'h11, 32'h22, 3'b000, 0, 0, 0); cyc("bp_load");
        out_ready = 1'b0;
        send(7'b0110011, 3'b110, 1'b0, 32'h33, 32'h44, 0, 0, 32'h33, 32'h44, 3'b011, 0, 0, 0);
        cyc("stall0"); cyc("stall1"); cyc("stall2");
        out_ready = 1'b1; cyc("swap");
        idle(); cyc("bp_drain");
        cyc("bp_empty");

        // ---- flush during stall with a new instruction offered ----
        send(7'b0110011, 3'b100, 1'b0, 32'h1, 32'h2, 0, 0, 32'h1, 32'h2, 3'b101, 0, 0, 0); cyc("fl_load");
        out_ready = 1'b0;
        send(7'b1100011, 3'b001, 1'b0, 32'h5, 32'h6, 0, 0, 32'h5, 32'h6, 3'b001, 1, 1, 0);
        cyc("fl_stall");
        flush = 1'b1; cyc("flush");
        flush = 1'b0; idle(); cyc("fl_after");
        out_ready = 1'b1; cyc("fl_empty");

        // ---- reset during stall ----
        send(7'b1100011, 3'b000, 1'b0, 32'h5, 32'h6, 0, 0, 32'h5, 32'h6, 3'b001, 1, 0, 0); cyc("rs_load");
        out_ready = 1'b0;
        send(7'b0010011, 3'b111, 1'b0, 32'hF, 0, 32'h3, 0, 32'hF, 32'h3, 3'b010, 0, 0, 0);
        cyc("rs_stall");
        rst = 1'b1; cyc("rst");
        rst = 1'b0; idle();
        check_zero("rst_after");
        out_ready = 1'b1;
        cyc("rs_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
